// File: rtl/n_input_gate_sweep_if.sv
// Operand/result bundle for the programmable N-input gate and its sweep engine.
// Handshake: i_valid qualifies i_in/i_code on the same edge with no back-pressure;
// o_valid qualifies o_f/o_vec for exactly one cycle per result.
interface n_input_gate_sweep_if #(
   parameter int N = 3
);
   logic [N-1:0] i_in;
   logic [2:0]   i_code;
   logic         i_valid;
   logic         i_sweep_start;
   logic         o_f;
   logic         o_valid;
   logic [N+2:0] o_vec;
   logic         o_busy;
   logic         o_done;
   logic [N+3:0] o_ones_count;
   logic [1:0]   o_state;

   modport master (
      output i_in, i_code, i_valid, i_sweep_start,
      input  o_f, o_valid, o_vec, o_busy, o_done, o_ones_count, o_state
   );

   modport slave (
      input  i_in, i_code, i_valid, i_sweep_start,
      output o_f, o_valid, o_vec, o_busy, o_done, o_ones_count, o_state
   );
endinterface

// File: rtl/n_input_gate_sweep.sv
// Registered N-input programmable gate (8 reduction functions) with a built-in
// exhaustive sweep engine that counts ones over every {code, in} combination.
module n_input_gate_sweep #(
   parameter int N    = 3,
   parameter int PIPE = 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   n_input_gate_sweep_if.slave    bus
);
   localparam int W = N + 3;
   localparam logic [W-1:0] CNT_LAST = '1;
   localparam logic [W-1:0] CNT_ONE  = W'(1);
   localparam logic [W:0]   ONES_ONE = (W + 1)'(1);
   localparam logic [3:0]   HALF     = 4'(N / 2);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   cnt_q, cnt_d;
   logic [W:0]     ones_q, ones_d;
   logic           out_f_q, out_f_d;
   logic           out_valid_q, out_valid_d;
   logic [W-1:0]   out_vec_q, out_vec_d;

   logic           src_valid, src_tag;
   logic [W-1:0]   src_vec;
   logic           fin_valid, fin_tag;
   logic [W-1:0]   fin_vec;
   logic           pipe_has_tag;
   logic           f_comb;
   logic [3:0]     pop;
   logic [N-1:0]   ins;

   // Stage-1 source: external operands when idle, the sweep counter otherwise.
   always_comb begin
      src_valid = 1'b0;
      src_tag   = 1'b0;
      src_vec   = {bus.i_code, bus.i_in};
      case (state_q)
         S_IDLE, S_DONE: src_valid = bus.i_valid;
         S_SWEEP: begin
            src_valid = 1'b1;
            src_tag   = 1'b1;
            src_vec   = cnt_q;
         end
         default: ;
      endcase
   end

   generate
      if (PIPE == 2) begin : g_pipe2
         logic         p_valid_q, p_valid_d;
         logic         p_tag_q, p_tag_d;
         logic [W-1:0] p_vec_q, p_vec_d;

         always_comb begin
            p_valid_d = src_valid;
            p_tag_d   = src_tag;
            p_vec_d   = src_vec;
         end

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               p_valid_q <= 1'b0;
               p_tag_q   <= 1'b0;
               p_vec_q   <= '0;
            end else begin
               p_valid_q <= p_valid_d;
               p_tag_q   <= p_tag_d;
               p_vec_q   <= p_vec_d;
            end
         end

         assign fin_valid    = p_valid_q;
         assign fin_tag      = p_tag_q;
         assign fin_vec      = p_vec_q;
         assign pipe_has_tag = p_valid_q & p_tag_q;
      end else begin : g_pipe1
         assign fin_valid    = src_valid;
         assign fin_tag      = src_tag;
         assign fin_vec      = src_vec;
         assign pipe_has_tag = 1'b0;
      end
   endgenerate

   // Gate function evaluated just ahead of the output register.
   always_comb begin
      f_comb = 1'b0;
      pop    = '0;
      ins    = fin_vec[N-1:0];
      for (int i = 0; i < N; i++) begin
         pop = pop + {3'b000, ins[i]};
      end
      case (fin_vec[W-1:N])
         3'd0: f_comb = &ins;
         3'd1: f_comb = |ins;
         3'd2: f_comb = ^ins;
         3'd3: f_comb = ~(&ins);
         3'd4: f_comb = ~(|ins);
         3'd5: f_comb = ~(^ins);
         3'd6: f_comb = (pop > HALF);
         3'd7: f_comb = (pop == 4'd1);
         default: f_comb = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ones_d      = ones_q;
      out_valid_d = fin_valid;
      out_f_d     = out_f_q;
      out_vec_d   = out_vec_q;
      if (fin_valid) begin
         out_f_d   = f_comb;
         out_vec_d = fin_vec;
      end
      if (fin_valid && fin_tag && f_comb) begin
         ones_d = ones_q + ONES_ONE;
      end
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (bus.i_sweep_start) begin
               state_d = S_SWEEP;
               cnt_d   = '0;
               ones_d  = '0;
            end
         end
         S_SWEEP: begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d = S_DRAIN;
            end
         end
         // Leave only once the final tagged vector sits in the output register.
         S_DRAIN: begin
            if (!pipe_has_tag) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         ones_q      <= '0;
         out_f_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_vec_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ones_q      <= ones_d;
         out_f_q     <= out_f_d;
         out_valid_q <= out_valid_d;
         out_vec_q   <= out_vec_d;
      end
   end

   assign bus.o_f          = out_f_q;
   assign bus.o_valid      = out_valid_q;
   assign bus.o_vec        = out_vec_q;
   assign bus.o_busy       = (state_q == S_SWEEP) || (state_q == S_DRAIN);
   assign bus.o_done       = (state_q == S_DONE);
   assign bus.o_ones_count = ones_q;
   assign bus.o_state      = state_q;
endmodule

// File: tb/tb_n_input_gate_sweep.sv
// Bench for n_input_gate_sweep: external path, sweeps at N=3/PIPE=1 and
// N=4/PIPE=2, start collisions and reset mid-sweep.
module tb_n_input_gate_sweep;
   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [6:0] exp_q[$];

   n_input_gate_sweep_if #(.N(3)) bus3 ();
   n_input_gate_sweep_if #(.N(4)) bus4 ();

   n_input_gate_sweep #(.N(3), .PIPE(1)) u_dut3 (.i_clk(i_clk), .i_rst(i_rst), .bus(bus3.slave));
   n_input_gate_sweep #(.N(4), .PIPE(2)) u_dut4 (.i_clk(i_clk), .i_rst(i_rst), .bus(bus4.slave));

   // clock / reset
   always #5 i_clk = ~i_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Reference gate written from the function table, independent of the RTL.
   function automatic int ref_gate(input int code, input int vin, input int n);
      int ones;
      ones = 0;
      for (int b = 0; b < n; b++) begin
         if (((vin >> b) & 1) != 0) ones++;
      end
      case (code)
         0: return (ones == n) ? 1 : 0;
         1: return (ones != 0) ? 1 : 0;
         2: return (ones % 2 == 1) ? 1 : 0;
         3: return (ones != n) ? 1 : 0;
         4: return (ones == 0) ? 1 : 0;
         5: return (ones % 2 == 0) ? 1 : 0;
         6: return (2 * ones > n) ? 1 : 0;
         default: return (ones == 1) ? 1 : 0;
      endcase
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive3(input int code, input int vin, input logic vld, input logic start);
      bus3.i_code        = 3'(code);
      bus3.i_in          = 3'(vin);
      bus3.i_valid       = vld;
      bus3.i_sweep_start = start;
   endtask

   task automatic check_idle3(input string tag);
      check({tag, "_f"}, int'(bus3.o_f), 0);
      check({tag, "_valid"}, int'(bus3.o_valid), 0);
      check({tag, "_vec"}, int'(bus3.o_vec), 0);
      check({tag, "_busy"}, int'(bus3.o_busy), 0);
      check({tag, "_done"}, int'(bus3.o_done), 0);
      check({tag, "_ones"}, int'(bus3.o_ones_count), 0);
      check({tag, "_state"}, int'(bus3.o_state), 0);
   endtask

   // Sweep on the N=3/PIPE=1 instance; start is sampled at the next edge.
   task automatic sweep3(input logic with_ext, input logic restart_mid);
      logic [6:0] got;
      drive3(0, 7, with_ext, 1'b1);
      tick();
      drive3(0, 0, 1'b0, 1'b0);
      check("sw3_busy_t", int'(bus3.o_busy), 1);
      if (with_ext) begin
         check("sw3_ext_valid", int'(bus3.o_valid), 1);
         check("sw3_ext_vec", int'(bus3.o_vec), 7);
         check("sw3_ext_f", int'(bus3.o_f), 1);
      end
      for (int j = 0; j < 64; j++) begin
         bus3.i_sweep_start = (restart_mid && j == 10) ? 1'b1 : 1'b0;
         tick();
         check("sw3_valid", int'(bus3.o_valid), 1);
         check("sw3_vec", int'(bus3.o_vec), j);
         check("sw3_f", int'(bus3.o_f), ref_gate(j >> 3, j & 7, 3));
         check("sw3_done_early", int'(bus3.o_done), 0);
      end
      bus3.i_sweep_start = 1'b0;
      tick();
      check("sw3_done", int'(bus3.o_done), 1);
      check("sw3_busy_done", int'(bus3.o_busy), 0);
      check("sw3_valid_end", int'(bus3.o_valid), 0);
      check("sw3_ones", int'(bus3.o_ones_count), 31);
      tick();
      check("sw3_done_once", int'(bus3.o_done), 0);
      check("sw3_state_idle", int'(bus3.o_state), 0);
      tick();
      check("sw3_ones_hold", int'(bus3.o_ones_count), 31);
      got = '0;
      if (got != 0) check("unused", 0, 0);
   endtask

   initial begin
      drive3(0, 0, 1'b0, 1'b0);
      bus4.i_code = 3'd0;
      bus4.i_in = 4'd0;
      bus4.i_valid = 1'b0;
      bus4.i_sweep_start = 1'b0;
      i_rst = 1'b1;
      repeat (3) tick();
      check_idle3("rst3");
      check("rst4_valid", int'(bus4.o_valid), 0);
      check("rst4_busy", int'(bus4.o_busy), 0);
      check("rst4_ones", int'(bus4.o_ones_count), 0);
      i_rst = 1'b0;
      tick();

      // external path: 34 back-to-back vectors through the scoreboard queue
      for (int k = 0; k < 34; k++) begin
         drive3(k >> 3, k & 7, 1'b1, 1'b0);
         exp_q.push_back({6'(k), 1'(ref_gate(k >> 3, k & 7, 3))});
         tick();
         check("ext_valid", int'(bus3.o_valid), 1);
         if (exp_q.size() > 0) begin
            logic [6:0] e;
            e = exp_q.pop_front();
            check("ext_vec", int'(bus3.o_vec), int'(e[6:1]));
            check("ext_f", int'(bus3.o_f), int'(e[0]));
         end
      end
      drive3(0, 0, 1'b0, 1'b0);
      tick();
      check("ext_valid_off", int'(bus3.o_valid), 0);

      // hand-computed spot vectors
      drive3(2, 3'b101, 1'b1, 1'b0);
      tick();
      check("spot_xor101", int'(bus3.o_f), 0);
      drive3(6, 3'b011, 1'b1, 1'b0);
      tick();
      check("spot_maj011", int'(bus3.o_f), 1);
      drive3(7, 3'b100, 1'b1, 1'b0);
      tick();
      check("spot_onehot100", int'(bus3.o_f), 1);
      drive3(0, 0, 1'b0, 1'b0);
      tick();

      // sweep with simultaneous external vector and a mid-sweep restart
      sweep3(1'b1, 1'b1);

      // N=4, PIPE=2 sweep
      bus4.i_sweep_start = 1'b1;
      tick();
      bus4.i_sweep_start = 1'b0;
      check("sw4_busy_t", int'(bus4.o_busy), 1);
      tick();
      check("sw4_fill_valid", int'(bus4.o_valid), 0);
      for (int j = 0; j < 128; j++) begin
         tick();
         check("sw4_valid", int'(bus4.o_valid), 1);
         check("sw4_vec", int'(bus4.o_vec), j);
         check("sw4_f", int'(bus4.o_f), ref_gate(j >> 4, j & 15, 4));
         check("sw4_done_early", int'(bus4.o_done), 0);
      end
      tick();
      check("sw4_done", int'(bus4.o_done), 1);
      check("sw4_busy_done", int'(bus4.o_busy), 0);
      check("sw4_ones", int'(bus4.o_ones_count), 57);
      tick();
      check("sw4_done_once", int'(bus4.o_done), 0);
      check("sw4_ones_hold", int'(bus4.o_ones_count), 57);

      // reset at sweep vector 20
      drive3(0, 0, 1'b0, 1'b1);
      tick();
      bus3.i_sweep_start = 1'b0;
      for (int j = 0; j <= 20; j++) tick();
      check("mid_vec20", int'(bus3.o_vec), 20);
      i_rst = 1'b1;
      tick();
      check_idle3("mid_rst");
      i_rst = 1'b0;
      for (int j = 0; j < 3; j++) begin
         tick();
         check("post_rst_done", int'(bus3.o_done), 0);
         check("post_rst_busy", int'(bus3.o_busy), 0);
      end

      // fresh sweep, bounded wait for completion
      begin
         int budget;
         drive3(0, 0, 1'b0, 1'b1);
         tick();
         bus3.i_sweep_start = 1'b0;
         budget = 0;
         while (!bus3.o_done && budget < 200) begin
            tick();
            budget++;
         end
         check("fresh_done_seen", int'(bus3.o_done), 1);
         check("fresh_cycles", budget, 65);
         check("fresh_ones", int'(bus3.o_ones_count), 31);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
